// File: rtl/axi_slice_multi.sv
// Parametrised multi-lane valid/ready slice: NUM_CH independent lanes, each a
// bypass, a two-entry spill register or a DEPTH-entry FIFO, selected by MODE.
module axi_slice_multi #(
    parameter int NUM_CH        = 5,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int MODE          = 2,
    parameter int DEPTH         = 4,
    parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              test_en_i,
    input  logic [NUM_CH-1:0]                 slave_valid_i,
    input  logic [NUM_CH*PAYLOAD_WIDTH-1:0]   slave_data_i,
    output logic [NUM_CH-1:0]                 slave_ready_o,
    output logic [NUM_CH-1:0]                 master_valid_o,
    output logic [NUM_CH*PAYLOAD_WIDTH-1:0]   master_data_o,
    input  logic [NUM_CH-1:0]                 master_ready_i,
    input  logic [NUM_CH-1:0]                 flush_i,
    output logic [NUM_CH*CNT_WIDTH-1:0]       fill_o,
    output logic                              idle_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic              unused_test_en;
    logic [NUM_CH-1:0] lane_empty;

    assign unused_test_en = test_en_i;
    assign idle_o         = &lane_empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            if (MODE == 0) begin : g_bypass
                logic unused_bypass;
                assign unused_bypass = clk_i ^ rst_ni ^ flush_i[gi];

                assign master_valid_o[gi] = slave_valid_i[gi];
                assign master_data_o[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] =
                    slave_data_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                assign slave_ready_o[gi] = master_ready_i[gi];
                assign fill_o[gi*CNT_WIDTH +: CNT_WIDTH] = '0;
                assign lane_empty[gi] = 1'b1;

            end else if (MODE == 1) begin : g_spill
                // State doubles as the occupancy: EMPTY=0, ONE=1, FULL=2.
                logic [1:0]               state_q, state_d;
                logic [PAYLOAD_WIDTH-1:0] a_q, a_d;
                logic [PAYLOAD_WIDTH-1:0] b_q, b_d;
                logic [PAYLOAD_WIDTH-1:0] in_data;
                logic                     ready;
                logic                     push;
                logic                     pop;

                assign in_data = slave_data_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                assign ready   = rst_ni & ~flush_i[gi] & (state_q != S_FULL);
                assign push    = slave_valid_i[gi] & ready;
                assign pop     = (state_q != S_EMPTY) & master_ready_i[gi];

                always_comb begin
                    state_d = state_q;
                    a_d     = a_q;
                    b_d     = b_q;
                    if (flush_i[gi]) begin
                        state_d = S_EMPTY;
                    end else begin
                        case (state_q)
                            S_EMPTY: begin
                                if (push) begin
                                    state_d = S_ONE;
                                    a_d     = in_data;
                                end
                            end
                            S_ONE: begin
                                if (push && pop) begin
                                    a_d = in_data;
                                end else if (push) begin
                                    state_d = S_FULL;
                                    b_d     = in_data;
                                end else if (pop) begin
                                    state_d = S_EMPTY;
                                end
                            end
                            S_FULL: begin
                                if (pop) begin
                                    state_d = S_ONE;
                                    a_d     = b_q;
                                end
                            end
                            default: state_d = S_EMPTY;
                        endcase
                    end
                end

                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        state_q <= S_EMPTY;
                    end else begin
                        state_q <= state_d;
                    end
                    a_q <= a_d;
                    b_q <= b_d;
                end

                assign master_valid_o[gi] = (state_q != S_EMPTY);
                assign master_data_o[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = a_q;
                assign slave_ready_o[gi] = ready;
                assign fill_o[gi*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(state_q);
                assign lane_empty[gi] = (state_q == S_EMPTY);

            end else begin : g_fifo
                logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];
                logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
                logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
                logic [CNT_WIDTH-1:0]     count_q, count_d;
                logic                     ready;
                logic                     push;
                logic                     pop;

                assign ready = rst_ni & ~flush_i[gi] & (count_q != CNT_WIDTH'(DEPTH));
                assign push  = slave_valid_i[gi] & ready;
                assign pop   = (count_q != '0) & master_ready_i[gi];

                always_comb begin
                    rd_ptr_d = rd_ptr_q;
                    wr_ptr_d = wr_ptr_q;
                    count_d  = count_q;
                    if (flush_i[gi]) begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        count_d  = '0;
                    end else begin
                        // Explicit wrap so DEPTH need not be a power of two.
                        if (push) begin
                            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                        end
                        if (pop) begin
                            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                        end
                        if (push && !pop) begin
                            count_d = count_q + CNT_WIDTH'(1);
                        end else if (pop && !push) begin
                            count_d = count_q - CNT_WIDTH'(1);
                        end
                    end
                end

                always_ff @(posedge clk_i) begin
                    if (!rst_ni) begin
                        rd_ptr_q <= '0;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                    end else begin
                        rd_ptr_q <= rd_ptr_d;
                        wr_ptr_q <= wr_ptr_d;
                        count_q  <= count_d;
                    end
                end

                always_ff @(posedge clk_i) begin
                    if (push) begin
                        mem_q[wr_ptr_q] <= slave_data_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                    end
                end

                assign master_valid_o[gi] = (count_q != '0);
                assign master_data_o[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = mem_q[rd_ptr_q];
                assign slave_ready_o[gi] = ready;
                assign fill_o[gi*CNT_WIDTH +: CNT_WIDTH] = count_q;
                assign lane_empty[gi] = (count_q == '0);
            end
        end
    endgenerate

endmodule
